// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-format encoding for the ID-stage immediate generator.
package imm_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRX = 3'b101;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SH  = 3'd6,
    FMT_BAD = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> immediate/format/illegal decode for RV32I/RV64I.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    imm_c,
  output fmt_e               fmt_c,
  output logic               illegal_c
);

  // Opcode-driven format select and sign-extending immediate assembly
  always_comb begin
    imm_c     = '0;
    fmt_c     = FMT_R;
    illegal_c = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt_c = FMT_I;
        imm_c = XLEN'($signed(instr[31:20]));
      end
      OPC_OP_IMM: begin
        if (instr[14:12] == FUNCT3_SLL || instr[14:12] == FUNCT3_SRX) begin
          if (XLEN == 32 && instr[25]) begin
            // shamt >= 32 has no meaning on a 32-bit datapath
            fmt_c     = FMT_BAD;
            illegal_c = 1'b1;
          end else if (XLEN == 32) begin
            fmt_c = FMT_SH;
            imm_c = XLEN'(instr[24:20]);
          end else begin
            fmt_c = FMT_SH;
            imm_c = XLEN'(instr[25:20]);
          end
        end else begin
          fmt_c = FMT_I;
          imm_c = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_STORE: begin
        fmt_c = FMT_S;
        imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        fmt_c = FMT_B;
        imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_c = FMT_U;
        imm_c = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt_c = FMT_J;
        imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OPC_OP: begin
        fmt_c = FMT_R;
      end
      default: begin
        fmt_c     = FMT_BAD;
        illegal_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator: one output register plus one skid entry.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output fmt_e               out_fmt,
  output logic               out_illegal,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [INSTR_W-1:0] skid_instr;
  logic               skid_valid;

  logic [INSTR_W-1:0] dec_in_c;
  logic [XLEN-1:0]    dec_imm_c;
  fmt_e               dec_fmt_c;
  logic               dec_illegal_c;

  logic               accept_c;
  logic               load_c;
  logic               out_valid_d;
  logic               skid_valid_d;
  logic               in_ready_d;
  logic [INSTR_W-1:0] skid_instr_d;
  logic [CNT_W-1:0]   cnt_d;

  // A held skid entry always drains first; while it is held in_ready is low,
  // so the single decoder never has to serve the input and the skid at once.
  assign dec_in_c = skid_valid ? skid_instr : in_instr;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr    (dec_in_c),
    .imm_c    (dec_imm_c),
    .fmt_c    (dec_fmt_c),
    .illegal_c(dec_illegal_c)
  );

  // Next-state for output/skid occupancy, ready and illegal counter
  always_comb begin
    accept_c     = in_valid && in_ready && !flush;
    load_c       = 1'b0;
    out_valid_d  = out_valid;
    skid_valid_d = skid_valid;
    skid_instr_d = skid_instr;
    cnt_d        = illegal_cnt;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        load_c       = 1'b1;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        load_c      = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_instr_d = in_instr;
      skid_valid_d = 1'b1;
    end

    if (accept_c && dec_illegal_c && illegal_cnt != CNT_MAX) begin
      cnt_d = illegal_cnt + CNT_W'(1);
    end

    in_ready_d = !skid_valid_d;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= FMT_R;
      out_illegal <= 1'b0;
      out_instr   <= '0;
      skid_instr  <= '0;
      skid_valid  <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      skid_instr  <= skid_instr_d;
      skid_valid  <= skid_valid_d;
      illegal_cnt <= cnt_d;
      if (load_c) begin
        out_imm     <= dec_imm_c;
        out_fmt     <= dec_fmt_c;
        out_illegal <= dec_illegal_c;
        out_instr   <= dec_in_c;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit/16-bit-counter instance and a 64-bit/2-bit-counter instance share stimulus.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;

  logic        r32, v32, il32;
  logic [31:0] imm32, ins32;
  fmt_e        f32;
  logic [15:0] c32;

  logic        r64, v64, il64;
  logic [63:0] imm64;
  logic [31:0] ins64;
  fmt_e        f64;
  logic [1:0]  c64;

  int checks   = 0;
  int failures = 0;

  logic [31:0] s_instr [4] = '{32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h0010006F};
  logic [63:0] s_imm32 [4] = '{64'hFFFFFFFC, 64'hFFFFFFF8, 64'h12345000, 64'h00000800};
  logic [63:0] s_imm64 [4] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                               64'h0000000012345000, 64'h0000000000000800};
  fmt_e        s_fmt   [4] = '{FMT_S, FMT_B, FMT_U, FMT_J};

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(f32), .out_illegal(il32), .out_instr(ins32), .illegal_cnt(c32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(f64), .out_illegal(il64), .out_instr(ins64), .illegal_cnt(c64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_instr  = '0;
    step();
    chk("rst_valid", 64'(v32), 64'h0);
    chk("rst_ready", 64'(r32), 64'h1);
    chk("rst_imm", 64'(imm32), 64'h0);
    chk("rst_fmt", 64'(f32), 64'(FMT_R));
    chk("rst_illegal", 64'(il32), 64'h0);
    chk("rst_instr", 64'(ins32), 64'h0);
    chk("rst_cnt", 64'(c32), 64'h0);
    #2 rst_n = 1'b1;

    // lw x1,-4(x2)
    in_valid = 1'b1;
    in_instr = 32'hFFC12083;
    step();
    chk("t1_valid", 64'(v32), 64'h1);
    chk("t1_imm", 64'(imm32), 64'hFFFFFFFC);
    chk("t1_fmt", 64'(f32), 64'(FMT_I));
    chk("t1_illegal", 64'(il32), 64'h0);
    chk("t1_instr", 64'(ins32), 64'hFFC12083);

    // back-to-back S/B/U/J stream, no bubbles
    for (int i = 0; i < 4; i++) begin
      in_instr = s_instr[i];
      step();
      chk("t2_valid", 64'(v32), 64'h1);
      chk("t2_imm32", 64'(imm32), s_imm32[i]);
      chk("t2_fmt", 64'(f32), 64'(s_fmt[i]));
      chk("t2_imm64", imm64, s_imm64[i]);
    end

    // backpressure: A to output, B to skid, C held off
    in_valid = 1'b0;
    step();
    chk("t3_drain", 64'(v32), 64'h0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    step();
    chk("t3_a_imm", 64'(imm32), 64'h1);
    chk("t3_a_ready", 64'(r32), 64'h1);
    in_instr = 32'h00200093;
    step();
    chk("t3_ready_low", 64'(r32), 64'h0);
    chk("t3_a_hold", 64'(imm32), 64'h1);
    in_instr = 32'h00300093;
    step();
    chk("t3_hold_valid", 64'(v32), 64'h1);
    chk("t3_hold_imm", 64'(imm32), 64'h1);
    chk("t3_hold_ready", 64'(r32), 64'h0);
    step();
    chk("t3_hold2_imm", 64'(imm32), 64'h1);
    out_ready = 1'b1;
    step();
    chk("t3_b_imm", 64'(imm32), 64'h2);
    chk("t3_b_ready", 64'(r32), 64'h1);
    step();
    chk("t3_c_imm", 64'(imm32), 64'h3);
    chk("t3_c_valid", 64'(v32), 64'h1);
    in_valid = 1'b0;
    step();
    chk("t3_empty", 64'(v32), 64'h0);

    // flush with both entries full and an illegal input pending
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00400093;
    step();
    in_instr = 32'h00500093;
    step();
    chk("t4_full", 64'(r32), 64'h0);
    in_instr = 32'h00000000;
    flush    = 1'b1;
    step();
    chk("t4_valid", 64'(v32), 64'h0);
    chk("t4_ready", 64'(r32), 64'h1);
    chk("t4_cnt", 64'(c32), 64'h0);
    step();
    chk("t4_in_drop_valid", 64'(v32), 64'h0);
    chk("t4_in_drop_cnt", 64'(c32), 64'h0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t4_no_ghost", 64'(v32), 64'h0);

    // illegal instructions and counter saturation
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    step();
    chk("t5_zero_illegal", 64'(il32), 64'h1);
    chk("t5_zero_imm", 64'(imm32), 64'h0);
    chk("t5_zero_fmt", 64'(f32), 64'(FMT_BAD));
    chk("t5_cnt32_1", 64'(c32), 64'h1);
    chk("t5_cnt64_1", 64'(c64), 64'h1);
    in_instr = 32'h02009093;
    step();
    chk("t5_sh_illegal", 64'(il32), 64'h1);
    chk("t5_sh_imm", 64'(imm32), 64'h0);
    chk("t5_cnt32_2", 64'(c32), 64'h2);
    chk("t5_sh64_fmt", 64'(f64), 64'(FMT_SH));
    chk("t5_sh64_imm", imm64, 64'd32);
    chk("t5_sh64_legal", 64'(il64), 64'h0);
    chk("t5_cnt64_hold", 64'(c64), 64'h1);
    in_instr = 32'h00000000;
    repeat (3) step();
    chk("t5_cnt32_5", 64'(c32), 64'h5);
    chk("t5_cnt64_sat", 64'(c64), 64'h3);

    // 64-bit sign extension of U and 6-bit shamt
    in_instr = 32'h800002B7;
    step();
    chk("t6_lui64", imm64, 64'hFFFFFFFF80000000);
    chk("t6_lui64_fmt", 64'(f64), 64'(FMT_U));
    chk("t6_lui32", 64'(imm32), 64'h80000000);
    in_instr = 32'h02109093;
    step();
    chk("t6_sh64_fmt", 64'(f64), 64'(FMT_SH));
    chk("t6_sh64_imm", imm64, 64'd33);
    chk("t6_sh32_illegal", 64'(il32), 64'h1);
    chk("t6_cnt32", 64'(c32), 64'h6);
    chk("t6_cnt64_sat", 64'(c64), 64'h3);

    // asynchronous reset with both entries occupied
    out_ready = 1'b0;
    in_instr  = 32'h00100093;
    step();
    step();
    chk("t7_full", 64'(r32), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("t7_valid", 64'(v32), 64'h0);
    chk("t7_ready", 64'(r32), 64'h1);
    chk("t7_cnt", 64'(c32), 64'h0);
    chk("t7_imm", 64'(imm32), 64'h0);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t7_after_valid", 64'(v32), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
